// File: rtl/program_loader.sv
// Boot-image loader: receives a count/data/checksum byte frame and
// writes the assembled 16-bit words into program memory.
module program_loader #(
    parameter int              ADDR_W    = 8,
    parameter int              DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              pm_wr_en,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [DATA_W-1:0] pm_wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state;
    state_t          state_nx;
    logic            ready_nx;
    logic            accept;
    logic [ADDR_W:0] remaining;
    logic [7:0]      hi_byte;
    logic [7:0]      csum;

    assign accept = in_valid && in_ready;

    // Next-state logic; in_ready is registered from the next state
    always_comb begin
        state_nx = state;
        ready_nx = 1'b0;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_nx = S_COUNT;
            S_COUNT: if (accept) state_nx = S_HI;
            S_HI:    if (accept) state_nx = S_LO;
            S_LO:
                if (accept)
                    state_nx = (remaining > ONE_CNT) ? S_HI : S_CHECK;
            S_CHECK:
                if (accept)
                    state_nx = (in_data == csum) ? S_DONE : S_ERROR;
            default: state_nx = S_IDLE;
        endcase
        ready_nx = (state_nx == S_COUNT) || (state_nx == S_HI) ||
                   (state_nx == S_LO) || (state_nx == S_CHECK);
    end

    // State register and handshake ready flop
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nx;
            in_ready <= ready_nx;
        end
    end

    // Datapath: count, checksum, word assembly, write port and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            pm_wr_en     <= 1'b0;
            pm_addr      <= '0;
            pm_wr_data   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            remaining    <= '0;
            hi_byte      <= '0;
            csum         <= '0;
        end else begin
            pm_wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        csum         <= '0;
                        busy         <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (accept)
                        remaining <= (in_data == 8'd0) ? FULL_CNT
                                   : (ADDR_W+1)'(in_data);
                end
                S_HI: begin
                    if (accept) begin
                        hi_byte <= in_data;
                        csum    <= csum + in_data;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        pm_wr_en     <= 1'b1;
                        pm_addr      <= BASE_ADDR
                                      + words_loaded[ADDR_W-1:0];
                        pm_wr_data   <= DATA_W'({hi_byte, in_data});
                        words_loaded <= words_loaded + ONE_CNT;
                        remaining    <= remaining - ONE_CNT;
                        csum         <= csum + in_data;
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        busy  <= 1'b0;
                        done  <= (in_data == csum);
                        error <= (in_data != csum);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: per-cycle vector table for the
// nominal frame plus hand-written multi-cycle sequences.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        pm_wr_en;
    logic [7:0]  pm_addr;
    logic [15:0] pm_wr_data;
    logic        busy, done, error;
    logic [8:0]  words_loaded;

    logic        w_start;
    logic [7:0]  w_data;
    logic        w_valid;
    logic        w_ready;
    logic        w_wr_en;
    logic [7:0]  w_addr;
    logic [15:0] w_wr_data;
    logic        w_busy, w_done, w_error;
    logic [8:0]  w_words;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wa[$];
    logic [15:0] wd[$];
    logic [7:0]  xa[$];
    logic [15:0] xd[$];

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(8), .DATA_W(16), .BASE_ADDR(8'h00)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .pm_wr_en(pm_wr_en), .pm_addr(pm_addr), .pm_wr_data(pm_wr_data),
        .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    program_loader #(.ADDR_W(8), .DATA_W(16), .BASE_ADDR(8'hFE)) u_wrap (
        .clk(clk), .rst(rst), .start(w_start),
        .in_data(w_data), .in_valid(w_valid), .in_ready(w_ready),
        .pm_wr_en(w_wr_en), .pm_addr(w_addr), .pm_wr_data(w_wr_data),
        .busy(w_busy), .done(w_done), .error(w_error),
        .words_loaded(w_words)
    );

    // Record every write pulse of each instance
    always @(negedge clk) begin
        if (pm_wr_en) begin
            wa.push_back(pm_addr);
            wd.push_back(pm_wr_data);
        end
        if (w_wr_en) begin
            xa.push_back(w_addr);
            xd.push_back(w_wr_data);
        end
    end

    typedef struct {
        logic        st;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdat;
        logic        bsy;
        logic        dn;
        logic        err;
        logic [8:0]  words;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [63:0] pack_out();
        return {26'd0, in_ready, pm_wr_en, pm_addr, pm_wr_data,
                busy, done, error, words_loaded};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gaps);
        int t;
        in_valid = 1'b0;
        repeat (gaps) tick();
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %b, wanted 1",
                     in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_w(input logic [7:0] b);
        int t;
        w_data  = b;
        w_valid = 1'b1;
        t = 0;
        while (!w_ready && t < 20) begin
            tick();
            t++;
        end
        if (!w_ready) begin
            checks++;
            errors++;
            $display("FAIL wrap_timeout: w_ready stayed %b, wanted 1",
                     w_ready);
        end
        tick();
        w_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_nominal_writes(input string name);
        chk({name, "_nwr"}, 64'(wa.size()), 64'd2);
        if (wa.size() == 2) begin
            chk({name, "_w0"}, {40'd0, wa[0], wd[0]}, {40'd0, 8'h00, 16'h60FF});
            chk({name, "_w1"}, {40'd0, wa[1], wd[1]}, {40'd0, 8'h01, 16'h61FE});
        end
    endtask

    logic [7:0] nom[6];

    initial begin
        logic [7:0] cs;
        int bad;

        nom[0] = 8'h02; nom[1] = 8'h60; nom[2] = 8'hFF;
        nom[3] = 8'h61; nom[4] = 8'hFE; nom[5] = 8'hBE;

        // st v  d      rdy we addr   wdat      bsy dn err words
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 9'd0};
        tbl[1] = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 9'd0};
        tbl[2] = '{1'b0, 1'b1, 8'h60, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 9'd0};
        tbl[3] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h00, 16'h60FF, 1'b1, 1'b0, 1'b0, 9'd1};
        tbl[4] = '{1'b0, 1'b1, 8'h61, 1'b1, 1'b0, 8'h00, 16'h60FF, 1'b1, 1'b0, 1'b0, 9'd1};
        tbl[5] = '{1'b0, 1'b1, 8'hFE, 1'b1, 1'b1, 8'h01, 16'h61FE, 1'b1, 1'b0, 1'b0, 9'd2};
        tbl[6] = '{1'b0, 1'b1, 8'hBE, 1'b0, 1'b0, 8'h01, 16'h61FE, 1'b0, 1'b1, 1'b0, 9'd2};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 16'h61FE, 1'b0, 1'b1, 1'b0, 9'd2};

        rst = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        w_start = 1'b0; w_data = 8'h00; w_valid = 1'b0;
        do_reset();

        chk("reset_outputs", pack_out(), 64'd0);
        chk("reset_wrap", {26'd0, w_ready, w_wr_en, w_addr, w_wr_data,
                           w_busy, w_done, w_error, w_words}, 64'd0);

        // Nominal frame, cycle by cycle
        wa.delete(); wd.delete();
        for (int i = 0; i < 8; i++) begin
            start    = tbl[i].st;
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            tick();
            start = 1'b0;
            chk($sformatf("vec%0d", i), pack_out(),
                {26'd0, tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].wdat,
                 tbl[i].bsy, tbl[i].dn, tbl[i].err, tbl[i].words});
        end
        in_valid = 1'b0;
        check_nominal_writes("nom");

        // Bad checksum: writes still happen, error latches, start clears it
        wa.delete(); wd.delete();
        do_start();
        for (int i = 0; i < 5; i++) send(nom[i], 0);
        send(8'hBF, 0);
        check_nominal_writes("bad");
        chk("bad_flags", {61'd0, error, done, in_ready}, {61'd0, 3'b100});
        chk("bad_busy", {63'd0, busy}, 64'd0);
        do_start();
        chk("bad_restart", {61'd0, error, busy, in_ready}, {61'd0, 3'b011});
        do_reset();

        // Backpressure: random idle cycles between bytes
        wa.delete(); wd.delete();
        do_start();
        for (int i = 0; i < 6; i++) send(nom[i], $urandom_range(0, 4));
        repeat (3) tick();
        check_nominal_writes("gap");
        chk("gap_flags", {60'd0, done, error, busy, in_ready},
            {60'd0, 4'b1000});
        chk("gap_words", 64'(words_loaded), 64'd2);

        // Reset in the middle of a frame
        wa.delete(); wd.delete();
        do_start();
        for (int i = 0; i < 4; i++) send(nom[i], 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_outputs", pack_out(), 64'd0);
        chk("midrst_nwr", 64'(wa.size()), 64'd1);
        if (wa.size() == 1)
            chk("midrst_w0", {40'd0, wa[0], wd[0]}, {40'd0, 8'h00, 16'h60FF});

        // A full frame afterwards completes normally
        wa.delete(); wd.delete();
        do_start();
        for (int i = 0; i < 6; i++) send(nom[i], 0);
        check_nominal_writes("after");
        chk("after_done", {62'd0, done, error}, {62'd0, 2'b10});

        // start pulse while in HI is ignored
        wa.delete(); wd.delete();
        do_start();
        send(nom[0], 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hi_start_busy", {62'd0, busy, in_ready}, {62'd0, 2'b11});
        for (int i = 1; i < 6; i++) send(nom[i], 0);
        check_nominal_writes("hist");
        chk("hist_done", {62'd0, done, error}, {62'd0, 2'b10});
        chk("hist_words", 64'(words_loaded), 64'd2);

        // Full 256-word image at BASE_ADDR 0xFE, wrapping addresses
        xa.delete(); xd.delete();
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        send_w(8'h00);
        cs = 8'h00;
        for (int i = 0; i < 256; i++) begin
            send_w(8'h00);
            send_w(8'(i));
            cs = cs + 8'(i);
        end
        send_w(cs);
        tick();
        chk("wrap_cs_const", 64'(cs), 64'h80);
        chk("wrap_npulse", 64'(xa.size()), 64'd256);
        if (xa.size() == 256) begin
            chk("wrap_first", 64'(xa[0]), 64'hFE);
            chk("wrap_third", 64'(xa[2]), 64'h00);
            chk("wrap_last", 64'(xa[255]), 64'hFD);
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (xd[i] !== 16'(i) || xa[i] !== 8'(8'hFE + i)) bad++;
            chk("wrap_payload", 64'(bad), 64'd0);
        end
        chk("wrap_words", 64'(w_words), 64'd256);
        chk("wrap_flags", {61'd0, w_done, w_error, w_busy},
            {61'd0, 3'b100});

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the 256x16 instruction store: streams a boot image into program memory over a byte-wide valid/ready link.
- Frame format: count byte, then data bytes (high byte first per word), then checksum byte.
- Assembles 16-bit words and drives the program-memory write port at incrementing addresses.
- Flags completion or checksum failure so the control unit can hold the core in reset until the image is loaded.

Parameters:
- ADDR_W, 8, program-memory address width; memory depth is 2^ADDR_W.
- DATA_W, 16, instruction word width; fixed at 2 bytes per word.
- BASE_ADDR, 0, first address written; ADDR_W bits wide.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle pulse that begins a frame; ignored unless state is IDLE, DONE or ERROR.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- pm_wr_en  output  1  program-memory write strobe, one cycle per word.
- pm_addr  output  ADDR_W  write address.
- pm_wr_data  output  DATA_W  write data.
- busy  output  1  frame in progress.
- done  output  1  frame completed with good checksum; sticky until next start or rst.
- error  output  1  checksum mismatch; sticky until next start or rst.
- words_loaded  output  ADDR_W+1  number of words written in the current or last frame.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE. All outputs 0: in_ready, pm_wr_en, pm_addr, pm_wr_data, busy, done, error, words_loaded. Internal count, checksum and byte latch are cleared.
- Handshake: a byte is accepted on the edge where in_valid && in_ready. in_ready is a registered function of state:
  - 1 in COUNT, HI, LO and CHECK.
  - 0 in IDLE, DONE and ERROR.
- States:
  - IDLE/DONE/ERROR --start--> COUNT. Clears done, error, words_loaded and the checksum accumulator; sets busy=1.
  - COUNT --accept--> HI. Latches N = in_data; N=0 means 2^ADDR_W words (256).
  - HI --accept--> LO. Latches the high byte.
  - LO --accept--> HI if words remaining > 1, else CHECK. Issues the write for the completed word.
  - CHECK --accept--> DONE if in_data equals the checksum, else ERROR. busy=0 in both.
- Write timing: the edge that accepts the LO byte registers the following for exactly one cycle:
  - pm_wr_en=1
  - pm_addr = (BASE_ADDR + index) mod 2^ADDR_W
  - pm_wr_data = {hi, lo}
  - words_loaded increments on the same edge.
  - pm_wr_en is 0 on all other cycles. pm_addr and pm_wr_data hold their last values.
- Address wrap-around: index runs 0..N-1; the address wraps modulo 2^ADDR_W with no error.
- Checksum: 8-bit sum modulo 256 of all data bytes (HI and LO). The count byte and checksum byte are excluded.
- Stalls: in_valid=0 holds the state indefinitely. No timeout, no spurious writes.
- Simultaneous events:
  - start while busy is ignored.
  - start in the same cycle as rst: rst wins.
- Reset mid-frame: return to IDLE immediately. Words already written stay in memory; no partial write is issued.
- ERROR does not undo earlier writes. The control unit must not release the core unless done=1.

Test Plan:
- Nominal 2-word load, BASE_ADDR=0: start, then bytes 02,60,FF,61,FE,BE.
  - Writes addr 0 = 0x60FF, then addr 1 = 0x61FE, each a single-cycle pm_wr_en.
  - Result: done=1, error=0, busy=0, words_loaded=2.
- Bad checksum: same frame but checksum byte BF.
  - Both writes still occur.
  - Result: error=1, done=0, in_ready=0 afterwards; a new start clears error.
- Full image with wrap, BASE_ADDR=0xFE: count byte 00, 256 words with data = index, correct checksum.
  - Exactly 256 pulses; first address 0xFE, third 0x00, last 0xFD.
  - Result: words_loaded=256, done=1.
- Backpressure/gaps: insert random in_valid=0 cycles between the bytes of the nominal frame.
  - Identical writes and final flags; no write when a LO byte has not been accepted.
- Reset mid-frame: rst after the bytes 02,60,FF,61 are accepted.
  - One write done (addr 0 = 0x60FF); the second is never written; all outputs 0.
  - A following full nominal frame completes normally.
- start pulsed in HI state: no effect on state, count or checksum; frame completes with done=1.
